// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-index width, the hardwired zero register
// and the hazard-unit state encoding.
package pipeline_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      HZ_IDLE  = 1'b0,
      HZ_STALL = 1'b1
   } hazard_state_e;

endpackage : pipeline_pkg

// File: rtl/hazard_src_match.sv
// Source-operand match for one in-flight destination register.
// Ports:
//   dst_reg         destination register of the older instruction
//   rs, rt          source registers of the instruction in ID
//   uses_rs/uses_rt the ID instruction actually reads that source
//   match_c         destination feeds a source that is read (never for $0)
module hazard_src_match
   import pipeline_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] dst_reg,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic                  uses_rs,
   input  logic                  uses_rt,
   output logic                  match_c
);

   // $0 is hardwired, so writes to it never create a dependency
   assign match_c = (dst_reg != REG_ADDR_W'(REG_ZERO)) &&
                    ((uses_rs && (dst_reg == rs)) || (uses_rt && (dst_reg == rt)));

endmodule : hazard_src_match

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand hazard unit sitting beside ID. Holds PC and IF/ID and
// bubbles ID/EX for a counted number of cycles, flushes IF/ID on a taken branch,
// and keeps a saturating count of stalled cycles.
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   ID_Rs/ID_Rt, ID_UsesRs/Rt    ID source registers and read flags
//   ID_IsBranch, BranchTaken     ID holds a branch / branch resolved taken
//   EX_Rd, EX_RegWrite, EX_MemRead      ID/EX destination info
//   MEM_Rd, MEM_RegWrite, MEM_MemRead   EX/MEM destination info
//   PC_WriteEnable, IFID_WriteEnable    1 = update (0 while stalling)
//   WriteEnableMuxControl        1 = pass ID controls, 0 = bubble
//   IFID_Flush                   zero IF/ID at next edge
//   StallActive                  stall this cycle
//   StallCycles                  saturating stalled-cycle count
module hazard_stall_controller
   import pipeline_pkg::*;
#(
   parameter int unsigned REG_ADDR_W   = 5,
   parameter int unsigned MEM_LAT      = 1,
   parameter int unsigned BRANCH_IN_ID = 1,
   parameter int unsigned CNT_W        = 3,
   parameter int unsigned PERF_W       = 32
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [REG_ADDR_W-1:0] ID_Rs,
   input  logic [REG_ADDR_W-1:0] ID_Rt,
   input  logic                  ID_UsesRs,
   input  logic                  ID_UsesRt,
   input  logic                  ID_IsBranch,
   input  logic                  BranchTaken,
   input  logic [REG_ADDR_W-1:0] EX_Rd,
   input  logic                  EX_RegWrite,
   input  logic                  EX_MemRead,
   input  logic [REG_ADDR_W-1:0] MEM_Rd,
   input  logic                  MEM_RegWrite,
   input  logic                  MEM_MemRead,
   output logic                  PC_WriteEnable,
   output logic                  IFID_WriteEnable,
   output logic                  WriteEnableMuxControl,
   output logic                  IFID_Flush,
   output logic                  StallActive,
   output logic [PERF_W-1:0]     StallCycles
);

   // Configuration guard: the counter must hold MEM_LAT+1 and a zero latency is meaningless
   if ((MEM_LAT == 0) || ((MEM_LAT + 1) > ((32'd1 << CNT_W) - 1))) begin : g_bad_cfg
      $error("hazard_stall_controller: MEM_LAT out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] ONE_N    = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAT_N    = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] LAT_BR_N = CNT_W'(MEM_LAT + 1);

   hazard_state_e      state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CNT_W-1:0]   n_req;
   logic               ex_match, mem_match;
   logic               branch_id;
   logic               ex_load_hit, br_ex_hit, br_mem_hit;
   logic               stall_c;

   hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_ex_match (
      .dst_reg (EX_Rd),
      .rs      (ID_Rs),
      .rt      (ID_Rt),
      .uses_rs (ID_UsesRs),
      .uses_rt (ID_UsesRt),
      .match_c (ex_match)
   );

   hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_match (
      .dst_reg (MEM_Rd),
      .rs      (ID_Rs),
      .rt      (ID_Rt),
      .uses_rs (ID_UsesRs),
      .uses_rt (ID_UsesRt),
      .match_c (mem_match)
   );

   // Hazard classification
   assign branch_id   = (BRANCH_IN_ID != 0) && ID_IsBranch;
   assign ex_load_hit = EX_MemRead && EX_RegWrite && ex_match;
   assign br_ex_hit   = branch_id && EX_RegWrite && !EX_MemRead && ex_match;
   assign br_mem_hit  = branch_id && MEM_MemRead && MEM_RegWrite && mem_match;

   // Required stall length: largest applicable rule wins
   always_comb begin
      n_req = '0;
      if (ex_load_hit) n_req = branch_id ? LAT_BR_N : LAT_N;
      if (br_ex_hit  && (n_req < ONE_N)) n_req = ONE_N;
      if (br_mem_hit && (n_req < LAT_N)) n_req = LAT_N;
   end

   // State / counter register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= HZ_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state; the first stall cycle is taken in IDLE so latency is zero
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_c   = 1'b0;
      case (state)
         HZ_IDLE: begin
            if (n_req != '0) begin
               stall_c = 1'b1;
               cnt_nxt = n_req - ONE_N;
               if (n_req > ONE_N) state_nxt = HZ_STALL;
            end
         end
         HZ_STALL: begin
            stall_c = 1'b1;
            cnt_nxt = cnt - ONE_N;
            if (cnt == ONE_N) state_nxt = HZ_IDLE;
         end
         default: begin
            state_nxt = HZ_IDLE;
            cnt_nxt   = '0;
         end
      endcase
      // Reset overrides everything visible this cycle
      if (Reset) stall_c = 1'b0;
   end

   assign PC_WriteEnable        = !stall_c;
   assign IFID_WriteEnable      = !stall_c;
   assign WriteEnableMuxControl = !stall_c;
   assign StallActive           = stall_c;
   // Taken branch during a stall is ignored: its operands are not valid yet
   assign IFID_Flush            = BranchTaken && !stall_c && !Reset;

   // Saturating stalled-cycle counter
   always_ff @(posedge Clock) begin
      if (Reset) begin
         StallCycles <= '0;
      end else if (stall_c && (StallCycles != '1)) begin
         StallCycles <= StallCycles + PERF_W'(1);
      end
   end

endmodule : hazard_stall_controller

// File: tb/tb_hazard_stall_controller.sv
// Randomized + directed bench; four configurations share one stimulus stream and
// are each compared against a cycle-level model of the stall rules.
module tb_hazard_stall_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_urs, id_urt, id_br, br_tk;
   logic       ex_rw, ex_mr, mem_rw, mem_mr;

   always #5 clk = ~clk;

   // config 0: LAT1, 1: LAT3, 2: LAT3 PERF_W=4, 3: LAT2 no branch checks
   int      lat_p [4] = '{1, 3, 3, 2};
   int      bid_p [4] = '{1, 1, 1, 0};
   longint  pmax  [4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
   int      rem   [4] = '{0, 0, 0, 0};
   longint  perf  [4] = '{0, 0, 0, 0};

   logic        pcw0, ifw0, wem0, fl0, sa0;
   logic        pcw1, ifw1, wem1, fl1, sa1;
   logic        pcw2, ifw2, wem2, fl2, sa2;
   logic        pcw3, ifw3, wem3, fl3, sa3;
   logic [31:0] sc0, sc1, sc3;
   logic [3:0]  sc2;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_stall_controller #(.MEM_LAT(1), .BRANCH_IN_ID(1), .CNT_W(3), .PERF_W(32)) u_l1 (
      .Clock(clk), .Reset(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_urs),
      .ID_UsesRt(id_urt), .ID_IsBranch(id_br), .BranchTaken(br_tk), .EX_Rd(ex_rd),
      .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .MEM_Rd(mem_rd), .MEM_RegWrite(mem_rw),
      .MEM_MemRead(mem_mr), .PC_WriteEnable(pcw0), .IFID_WriteEnable(ifw0),
      .WriteEnableMuxControl(wem0), .IFID_Flush(fl0), .StallActive(sa0), .StallCycles(sc0));

   hazard_stall_controller #(.MEM_LAT(3), .BRANCH_IN_ID(1), .CNT_W(3), .PERF_W(32)) u_l3 (
      .Clock(clk), .Reset(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_urs),
      .ID_UsesRt(id_urt), .ID_IsBranch(id_br), .BranchTaken(br_tk), .EX_Rd(ex_rd),
      .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .MEM_Rd(mem_rd), .MEM_RegWrite(mem_rw),
      .MEM_MemRead(mem_mr), .PC_WriteEnable(pcw1), .IFID_WriteEnable(ifw1),
      .WriteEnableMuxControl(wem1), .IFID_Flush(fl1), .StallActive(sa1), .StallCycles(sc1));

   hazard_stall_controller #(.MEM_LAT(3), .BRANCH_IN_ID(1), .CNT_W(3), .PERF_W(4)) u_p4 (
      .Clock(clk), .Reset(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_urs),
      .ID_UsesRt(id_urt), .ID_IsBranch(id_br), .BranchTaken(br_tk), .EX_Rd(ex_rd),
      .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .MEM_Rd(mem_rd), .MEM_RegWrite(mem_rw),
      .MEM_MemRead(mem_mr), .PC_WriteEnable(pcw2), .IFID_WriteEnable(ifw2),
      .WriteEnableMuxControl(wem2), .IFID_Flush(fl2), .StallActive(sa2), .StallCycles(sc2));

   hazard_stall_controller #(.MEM_LAT(2), .BRANCH_IN_ID(0), .CNT_W(3), .PERF_W(32)) u_nb (
      .Clock(clk), .Reset(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_urs),
      .ID_UsesRt(id_urt), .ID_IsBranch(id_br), .BranchTaken(br_tk), .EX_Rd(ex_rd),
      .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .MEM_Rd(mem_rd), .MEM_RegWrite(mem_rw),
      .MEM_MemRead(mem_mr), .PC_WriteEnable(pcw3), .IFID_WriteEnable(ifw3),
      .WriteEnableMuxControl(wem3), .IFID_Flush(fl3), .StallActive(sa3), .StallCycles(sc3));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   function automatic bit reads(input logic [4:0] r);
      return (r != 5'd0) && ((id_urs && r == id_rs) || (id_urt && r == id_rt));
   endfunction

   // Stall length demanded by the current ID/EX/MEM contents
   function automatic int needed(input int lat, input int bid);
      int n = 0;
      bit brq = (bid != 0) && id_br;
      if (ex_mr && ex_rw && reads(ex_rd)) n = lat + (brq ? 1 : 0);
      if (brq && ex_rw && !ex_mr && reads(ex_rd) && n < 1) n = 1;
      if (brq && mem_mr && mem_rw && reads(mem_rd) && n < lat) n = lat;
      return n;
   endfunction

   task automatic check_inst(input int i, input logic pcw, input logic ifw, input logic wem,
                             input logic fl, input logic sa, input logic [31:0] sc);
      int n = needed(lat_p[i], bid_p[i]);
      bit st = !rst && (rem[i] > 0 || n > 0);
      check_eq($sformatf("u%0d_stall", i), 32'(sa), 32'(st));
      check_eq($sformatf("u%0d_pc_we", i), 32'(pcw), 32'(!st));
      check_eq($sformatf("u%0d_ifid_we", i), 32'(ifw), 32'(!st));
      check_eq($sformatf("u%0d_mux", i), 32'(wem), 32'(!st));
      check_eq($sformatf("u%0d_flush", i), 32'(fl), 32'(br_tk && !st && !rst));
      check_eq($sformatf("u%0d_perf", i), sc, 32'(perf[i]));
      if (rst) begin
         rem[i]  = 0;
         perf[i] = 0;
      end else begin
         if (rem[i] > 0) rem[i]--;
         else if (n > 0) rem[i] = n - 1;
         if (st && perf[i] < pmax[i]) perf[i]++;
      end
   endtask

   task automatic step();
      #1;
      check_inst(0, pcw0, ifw0, wem0, fl0, sa0, sc0);
      check_inst(1, pcw1, ifw1, wem1, fl1, sa1, sc1);
      check_inst(2, pcw2, ifw2, wem2, fl2, sa2, 32'(sc2));
      check_inst(3, pcw3, ifw3, wem3, fl3, sa3, sc3);
      @(negedge clk);
   endtask

   task automatic clear_in();
      id_rs = '0; id_rt = '0; id_urs = 0; id_urt = 0; id_br = 0; br_tk = 0;
      ex_rd = '0; ex_rw = 0; ex_mr = 0; mem_rd = '0; mem_rw = 0; mem_mr = 0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic load_use(input logic [4:0] r);
      ex_rd = r; ex_rw = 1; ex_mr = 1; id_rs = r; id_urs = 1;
   endtask

   initial begin
      clear_in();
      rst = 1;
      repeat (2) @(negedge clk);

      // Load-use: one stall for LAT1, then the load leaves EX
      do_reset();
      load_use(5'd8);
      step();
      clear_in();
      step();
      step();
      check_eq("l1_lu_total", sc0, 32'd1);

      // LAT3 load-use with ID_Rs changing mid-stall still stalls 3 cycles
      do_reset();
      load_use(5'd8);
      step();
      id_rs = 5'd0;
      repeat (4) step();
      check_eq("l3_lu_total", sc1, 32'd3);

      // ALU result feeding a branch vs a non-branch
      do_reset();
      ex_rd = 5'd5; ex_rw = 1; id_rs = 5'd5; id_urs = 1; id_br = 1;
      step();
      clear_in();
      step();
      ex_rd = 5'd5; ex_rw = 1; id_rs = 5'd5; id_urs = 1; id_br = 0;
      step();
      check_eq("l1_branch_alu", sc0, 32'd1);

      // $0 never matches; taken branch without hazard flushes
      do_reset();
      load_use(5'd0);
      step();
      clear_in();
      br_tk = 1;
      step();
      clear_in();
      step();
      check_eq("l1_zero_reg", sc0, 32'd0);

      // Reset on the second stall cycle
      do_reset();
      load_use(5'd8);
      step();
      rst = 1;
      step();
      rst = 0;
      clear_in();
      #1;
      check_eq("l3_rst_stall", 32'(sa1), 32'd0);
      check_eq("l3_rst_perf", sc1, 32'd0);
      step();

      // Continuous stalling saturates the 4-bit counter
      do_reset();
      load_use(5'd9);
      repeat (25) step();
      check_eq("p4_saturate", 32'(sc2), 32'd15);
      check_eq("l3_no_sat", sc1, 32'd25);

      // Random traffic over a small register set to make matches frequent
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         rst    = ($urandom_range(0, 59) == 0);
         id_rs  = 5'($urandom_range(0, 3));
         id_rt  = 5'($urandom_range(0, 3));
         id_urs = 1'($urandom);
         id_urt = 1'($urandom);
         id_br  = ($urandom_range(0, 2) == 0);
         br_tk  = 1'($urandom);
         ex_rd  = 5'($urandom_range(0, 3));
         ex_rw  = 1'($urandom);
         ex_mr  = 1'($urandom);
         mem_rd = 5'($urandom_range(0, 3));
         mem_rw = 1'($urandom);
         mem_mr = 1'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_hazard_stall_controller
